// File: rtl/segundos1_dezena.sv
// Tens-of-seconds stopwatch digit: counts carry pulses modulo MODULUS, drives an active-low 7-segment digit.
// Optional macro BLINK_PAUSE_EN blinks the display while paused (half-period 2^BLINK_LOG2 cycles).
module segundos1_dezena #(
    parameter int MODULUS    = 6,
    parameter int BLINK_LOG2 = 24
) (
    input  logic       clock,
    input  logic       KEY0,
    input  logic       clockIN,
    input  logic       KEY1,
    input  logic       SW16,
    output logic [3:0] digit,
    output logic       clockOUT,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g
);

    typedef enum logic {RUN, PAUSED} state_t;

    localparam logic [3:0] LAST     = 4'(MODULUS - 1);
    localparam logic [6:0] SEG_ZERO = 7'b0000001;
    localparam logic [6:0] SEG_DARK = 7'b1111111;

    state_t     state;
    logic       key1_p0, key1_p1, key1_p2;
    logic       clkin_p0;
    logic       press;
    logic       inc;
    logic [6:0] seg;

    // Segment order {a,b,c,d,e,f,g}, 0 = lit.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = SEG_DARK;
        endcase
        return s;
    endfunction

    assign press = key1_p2 & ~key1_p1;
    assign inc   = clockIN & ~clkin_p0;
    assign {a, b, c, d, e, f, g} = seg;

    // Stage p0/p1: KEY1 synchronizer; p2 holds the previous synchronized level for edge detect.
    always_ff @(posedge clock or negedge KEY0) begin
        if (!KEY0) begin
            key1_p0  <= 1'b1;
            key1_p1  <= 1'b1;
            key1_p2  <= 1'b1;
            clkin_p0 <= 1'b0;
            state    <= RUN;
            digit    <= 4'd0;
            clockOUT <= 1'b0;
        end else begin
            key1_p0  <= KEY1;
            key1_p1  <= key1_p0;
            key1_p2  <= key1_p1;
            clkin_p0 <= clockIN;
            if (press)
                state <= (state == RUN) ? PAUSED : RUN;
            // Increment is judged against the pre-toggle state.
            if (SW16) begin
                digit    <= 4'd0;
                clockOUT <= 1'b0;
            end else if (state == RUN && inc) begin
                if (digit == LAST) begin
                    digit    <= 4'd0;
                    clockOUT <= 1'b1;
                end else begin
                    digit    <= digit + 4'd1;
                    clockOUT <= 1'b0;
                end
            end else begin
                clockOUT <= 1'b0;
            end
        end
    end

`ifdef BLINK_PAUSE_EN
    logic [BLINK_LOG2-1:0] blink_cnt;
    logic                  blank;

    always_ff @(posedge clock or negedge KEY0) begin
        if (!KEY0) begin
            blink_cnt <= '0;
            blank     <= 1'b0;
            seg       <= SEG_ZERO;
        end else begin
            if (state == PAUSED) begin
                blink_cnt <= blink_cnt + 1'b1;
                if (&blink_cnt)
                    blank <= ~blank;
            end else begin
                blink_cnt <= '0;
                blank     <= 1'b0;
            end
            seg <= blank ? SEG_DARK : decode(digit);
        end
    end
`else
    always_ff @(posedge clock or negedge KEY0) begin
        if (!KEY0)
            seg <= SEG_ZERO;
        else
            seg <= decode(digit);
    end
`endif

endmodule

// File: tb/tb_segundos1_dezena.sv
// Scoreboard bench for segundos1_dezena: stimulus queues expected digit/carry events, a monitor pops on each observed event.
module tb_segundos1_dezena;

    typedef struct packed {
        logic [3:0] d;
        logic       c;
    } ev_t;

    localparam logic [6:0] P0   = 7'b0000001;
    localparam logic [6:0] P4   = 7'b1001100;
    localparam logic [6:0] P5   = 7'b0100100;
    localparam logic [6:0] DARK = 7'b1111111;

    logic       clock = 1'b0;
    logic       KEY0 = 1'b0, clockIN = 1'b0, KEY1 = 1'b1, SW16 = 1'b0;
    logic [3:0] digit;
    logic       clockOUT, a, b, c, d, e, f, g;
    logic [6:0] seg;

    ev_t        q[$];
    logic       mon_en = 1'b0;
    logic [3:0] prev_digit = 4'd0;
    int         npass = 0;
    int         ntotal = 0;

    assign seg = {a, b, c, d, e, f, g};

    segundos1_dezena #(.MODULUS(6), .BLINK_LOG2(3)) dut (
        .clock(clock), .KEY0(KEY0), .clockIN(clockIN), .KEY1(KEY1), .SW16(SW16),
        .digit(digit), .clockOUT(clockOUT),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: any digit change or carry pulse is an event that must match the queue head.
    always @(negedge clock) begin
        if (mon_en) begin
            if (digit !== prev_digit || clockOUT !== 1'b0) begin
                if (q.size() == 0) begin
                    ntotal++;
                    $display("FAIL unexpected_event: got digit=%0d clockOUT=%0b expected no event at %0t",
                             digit, clockOUT, $time);
                end else begin
                    ev_t exp;
                    exp = q.pop_front();
                    check("event_digit", {4'd0, digit}, {4'd0, exp.d});
                    check("event_carry", {7'd0, clockOUT}, {7'd0, exp.c});
                end
            end
            prev_digit = digit;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic pulse();
        clockIN = 1'b1;
        cyc(1);
        clockIN = 1'b0;
        cyc(9);
    endtask

    task automatic push(input logic [3:0] dv, input logic cv);
        ev_t ev;
        ev.d = dv;
        ev.c = cv;
        q.push_back(ev);
    endtask

    task automatic press_key();
        KEY1 = 1'b0;
        cyc(5);
        KEY1 = 1'b1;
        cyc(5);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] samp [48];
        int         last_t, ntrans;
        logic       vals_ok, period_ok;

        cyc(3);
        check("reset_digit", {4'd0, digit}, 8'd0);
        check("reset_carry", {7'd0, clockOUT}, 8'd0);
        check("reset_seg", {1'b0, seg}, {1'b0, P0});
        KEY0 = 1'b1;
        prev_digit = 4'd0;
        mon_en = 1'b1;
        cyc(3);

        // Six pulses: 1,2,3,4,5 then wrap with carry.
        for (int i = 1; i <= 6; i++) begin
            push(4'(i % 6), i == 6);
            pulse();
            if (i == 5) check("seg_five", {1'b0, seg}, {1'b0, P5});
        end
        check("seg_after_wrap", {1'b0, seg}, {1'b0, P0});

        // Held-high carry counts once.
        push(4'd1, 1'b0);
        clockIN = 1'b1;
        cyc(20);
        clockIN = 1'b0;
        cyc(5);

        // Pause: three pulses discarded, resume, next pulse counts.
        press_key();
        for (int i = 0; i < 3; i++) pulse();
        press_key();
        push(4'd2, 1'b0);
        pulse();
        push(4'd3, 1'b0);
        pulse();
        push(4'd4, 1'b0);
        pulse();

        // Pause at 4 and observe the display.
        KEY1 = 1'b0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clock);
            samp[i] = seg;
            if (i == 5) KEY1 = 1'b1;
        end
        cyc(1);
`ifdef BLINK_PAUSE_EN
        vals_ok = 1'b1;
        period_ok = 1'b1;
        last_t = -1;
        ntrans = 0;
        for (int i = 0; i < 48; i++) begin
            if (samp[i] !== P4 && samp[i] !== DARK) vals_ok = 1'b0;
            if (i > 0 && samp[i] !== samp[i-1]) begin
                if (last_t >= 0 && (i - last_t) != 8) period_ok = 1'b0;
                last_t = i;
                ntrans++;
            end
        end
        check("blink_first_visible", {1'b0, samp[0]}, {1'b0, P4});
        check("blink_values", {7'd0, vals_ok}, 8'd1);
        check("blink_period", {7'd0, period_ok}, 8'd1);
        check("blink_toggles", {7'd0, ntrans >= 3}, 8'd1);
`else
        vals_ok = 1'b1;
        for (int i = 0; i < 48; i++)
            if (samp[i] !== P4) vals_ok = 1'b0;
        check("steady_four", {7'd0, vals_ok}, 8'd1);
        check("steady_four_last", {1'b0, samp[47]}, {1'b0, P4});
`endif
        press_key();
        push(4'd5, 1'b0);
        pulse();

        // Clear wins over a simultaneous increment at the last value.
        push(4'd0, 1'b0);
        SW16 = 1'b1;
        clockIN = 1'b1;
        cyc(1);
        SW16 = 1'b0;
        clockIN = 1'b0;
        cyc(5);
        check("seg_after_clear", {1'b0, seg}, {1'b0, P0});

        // Async reset while paused at 3 and mid-pulse.
        push(4'd1, 1'b0);
        pulse();
        push(4'd2, 1'b0);
        pulse();
        push(4'd3, 1'b0);
        pulse();
        press_key();
        push(4'd0, 1'b0);
        clockIN = 1'b1;
        #1;
        KEY0 = 1'b0;
        #1;
        check("async_rst_digit", {4'd0, digit}, 8'd0);
        check("async_rst_carry", {7'd0, clockOUT}, 8'd0);
        check("async_rst_seg", {1'b0, seg}, {1'b0, P0});
        cyc(1);
        clockIN = 1'b0;
        KEY0 = 1'b1;
        cyc(3);
        push(4'd1, 1'b0);
        pulse();

        for (int i = 0; i < 50 && q.size() != 0; i++) cyc(1);
        check("queue_drained", 8'(q.size()), 8'd0);

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
